// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   RESET_PC_DEFAULT : first fetch address after reset
//   ADEL_BIT_DEFAULT : exception flag bit for a misaligned fetch PC
//   if_state_e       : fetch FSM states (request / wait for data / hold instruction)
//   exc_flag()       : one-hot exception word for a given flag bit
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam int unsigned ADEL_BIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  function automatic logic [31:0] exc_flag(input int unsigned bit_idx);
    exc_flag = 32'd1 << bit_idx;
  endfunction

endpackage

// File: rtl/if_pc_sel.sv
// Next-PC priority mux for the fetch stage.
//   exception, exception_pc : flush redirect (highest priority)
//   redir_pend, redir_tgt   : pending branch redirect after the delay slot
//   pc                      : current fetch PC
//   next_pc                 : selected next PC (pc + 4 wraps at 32 bits)
module if_pc_sel (
  input  logic        exception,
  input  logic [31:0] exception_pc,
  input  logic        redir_pend,
  input  logic [31:0] redir_tgt,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc + 32'd4;
    if (exception) begin
      next_pc = exception_pc;
    end else if (redir_pend) begin
      next_pc = redir_tgt;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over an SRAM-like bus and
// holds {pc, inst, exception_type} for the IF/ID register.
//   clock_i, reset_i (async, active-low)
//   stall_i[0]          : 1 holds the current instruction in IF
//   exception_i/_pc_i   : flush and redirect to handler
//   branch_flag_i/_target_i : taken branch, applied after the delay slot
//   inst_req_o/addr_o, inst_addr_ok_i, inst_data_ok_i, inst_rdata_i : fetch bus
//   if_pc_o, if_inst_o, if_exception_type_o : held instruction (0 when none)
//   stall_req_o         : 1 while no valid instruction is held
// Optional: define IF_STAGE_PERF_EN to add perf_fetch_stall_o, a free-running
// count of cycles with stall_req_o=1.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned ADEL_BIT = ADEL_BIT_DEFAULT
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [3:0]  stall_i,
  input  logic        exception_i,
  input  logic [31:0] exception_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_exception_type_o,
  output logic        stall_req_o
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] perf_fetch_stall_o
`endif
);

  if_state_e   state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        redir_pend;
  logic [31:0] redir_tgt;
  logic        pc_aligned;
  logic        take_fetch;
  logic        take_adel;
  logic        consume;
  logic        unused_stall;

  assign unused_stall = ^stall_i[3:1];
  assign pc_aligned   = (pc[1:0] == 2'b00);

  assign inst_req_o  = reset_i & (state_q == S_REQ) & pc_aligned;
  assign inst_addr_o = pc;
  assign stall_req_o = (state_q != S_HOLD);

  if_pc_sel u_pc_sel (
    .exception    (exception_i),
    .exception_pc (exception_pc_i),
    .redir_pend   (redir_pend),
    .redir_tgt    (redir_tgt),
    .pc           (pc),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= S_REQ;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    take_fetch = 1'b0;
    take_adel  = 1'b0;
    consume    = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (exception_i) begin
          // The old address was accepted in the flush cycle: its data is stale.
          if (inst_req_o && inst_addr_ok_i) begin
            state_d  = S_WAIT;
            cancel_d = 1'b1;
          end
        end else if (!pc_aligned) begin
          take_adel = 1'b1;
          state_d   = S_HOLD;
        end else if (inst_addr_ok_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok_i) begin
          if (exception_i || cancel_q) begin
            state_d  = S_REQ;
            cancel_d = 1'b0;
          end else begin
            take_fetch = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (exception_i) begin
          cancel_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (exception_i) begin
          state_d = S_REQ;
        end else if (!stall_i[0]) begin
          consume = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      pc                  <= RESET_PC;
      redir_pend          <= 1'b0;
      redir_tgt           <= '0;
      if_pc_o             <= '0;
      if_inst_o           <= '0;
      if_exception_type_o <= '0;
    end else begin
      if (exception_i || consume) begin
        pc <= next_pc;
      end

      // A branch pulse in the consuming cycle belongs to the next instruction,
      // so it is applied after the consume clears the old redirect.
      if (exception_i) begin
        redir_pend <= 1'b0;
      end else begin
        if (consume) begin
          redir_pend <= 1'b0;
        end
        if (branch_flag_i) begin
          redir_pend <= 1'b1;
          redir_tgt  <= branch_target_i;
        end
      end

      if (exception_i || consume) begin
        if_pc_o             <= '0;
        if_inst_o           <= '0;
        if_exception_type_o <= '0;
      end else if (take_fetch) begin
        if_pc_o             <= pc;
        if_inst_o           <= inst_rdata_i;
        if_exception_type_o <= '0;
      end else if (take_adel) begin
        if_pc_o             <= pc;
        if_inst_o           <= '0;
        if_exception_type_o <= exc_flag(ADEL_BIT);
      end
    end
  end

`ifdef IF_STAGE_PERF_EN
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      perf_fetch_stall_o <= '0;
    end else if (stall_req_o) begin
      perf_fetch_stall_o <= perf_fetch_stall_o + 32'd1;
    end
  end
`endif

endmodule
